// File: rtl/pm_sample_pacer.sv
// pm_sample_pacer: buffers bursty UART bytes in a FIFO and replays them at a fixed sample rate.
// Optional build macro PACER_STATS_EN adds saturating overflow/underrun counters.
module pm_sample_pacer #(
  parameter int unsigned AW       = 9,
  parameter int unsigned RATE_DIV = 1563,
  parameter int unsigned PREFILL  = 256,
  parameter logic [7:0]  IDLE_VAL = 8'h7F
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
`ifdef PACER_STATS_EN
  input  logic          clr_stats,
  output logic [15:0]   ovf_count,
  output logic [15:0]   udr_count,
`endif
  output logic [7:0]    sample,
  output logic          sample_stb,
  output logic          playing,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underrun
);

  localparam int unsigned DEPTH_I   = 2 ** AW;
  localparam int unsigned CW        = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(RATE_DIV - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH_I);
  localparam logic [AW:0]   PREFILL_L = (AW+1)'(PREFILL);

  typedef enum logic [0:0] {S_BUFFER = 1'b0, S_PLAY = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_mem [0:DEPTH_I-1];
  logic [7:0]    r_sample;
  logic          r_stb;
  logic          r_playing;
  logic          r_overflow;
  logic          r_underrun;

  logic w_tick, w_full, w_empty, w_wr, w_pop_req, w_pop, w_udr;

  assign w_tick    = (r_cnt == TICK_LAST);
  assign w_full    = (r_level == DEPTH_L);
  assign w_empty   = (r_level == {(AW+1){1'b0}});
  // Full is judged on the pre-cycle level, so a same-cycle pop never frees room.
  assign w_wr      = in_valid && !w_full;
  assign w_pop_req = (r_state == S_PLAY) && w_tick;
  assign w_pop     = w_pop_req && !w_empty;
  assign w_udr     = w_pop_req && w_empty;

  // Rate divider, free-running in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= {CW{1'b0}};
    else if (w_tick) r_cnt <= {CW{1'b0}};
    else             r_cnt <= r_cnt + CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_BUFFER;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: prefill gate into PLAY, underrun drops back to BUFFER.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BUFFER: begin
        if (r_level >= PREFILL_L) w_state_nxt = S_PLAY;
        else                      w_state_nxt = S_BUFFER;
      end
      S_PLAY: begin
        if (w_udr) w_state_nxt = S_BUFFER;
        else       w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_BUFFER;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_level <= {(AW+1){1'b0}};
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      else       r_wptr <= r_wptr;
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      else       r_rptr <= r_rptr;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sample storage; contents are discarded logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= in_data;
  end

  // Synchronous head read lands the new sample one cycle after the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_sample <= IDLE_VAL;
    else if (w_pop) r_sample <= r_mem[r_rptr];
    else            r_sample <= r_sample;
  end

  // Registered status pulses and play flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stb      <= 1'b0;
      r_playing  <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_stb      <= w_pop;
      r_playing  <= (w_state_nxt == S_PLAY);
      r_overflow <= in_valid && w_full;
      r_underrun <= w_udr;
    end
  end

`ifdef PACER_STATS_EN
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_udr_cnt;

  // Saturating event counters; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= 16'h0000;
      r_udr_cnt <= 16'h0000;
    end else if (clr_stats) begin
      r_ovf_cnt <= 16'h0000;
      r_udr_cnt <= 16'h0000;
    end else begin
      if (r_overflow && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      else                                       r_ovf_cnt <= r_ovf_cnt;
      if (r_underrun && (r_udr_cnt != 16'hFFFF)) r_udr_cnt <= r_udr_cnt + 16'd1;
      else                                       r_udr_cnt <= r_udr_cnt;
    end
  end

  assign ovf_count = r_ovf_cnt;
  assign udr_count = r_udr_cnt;
`endif

  assign sample     = r_sample;
  assign sample_stb = r_stb;
  assign playing    = r_playing;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_pm_sample_pacer.sv
// Self-checking bench for pm_sample_pacer: randomized stimulus against a queue-based sample model.
// Runs with a shortened RATE_DIV to keep runtime small; handles PACER_STATS_EN builds too.
module tb_pm_sample_pacer;
  localparam int AW       = 9;
  localparam int DEPTH    = 512;
  localparam int RATE_DIV = 20;
  localparam int PREFILL  = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic [7:0]    sample;
  logic          sample_stb;
  logic          playing;
  logic [AW:0]   level;
  logic          overflow;
  logic          underrun;
`ifdef PACER_STATS_EN
  logic          clr_stats;
  logic [15:0]   ovf_count;
  logic [15:0]   udr_count;
  logic [15:0]   m_ovf_cnt;
  logic [15:0]   m_udr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: byte queue, tick phase, play flag, last sample and pulses.
  logic [7:0] m_q[$];
  int         m_cnt;
  bit         m_play;
  logic [7:0] m_sample;
  bit         m_stb, m_ovf, m_udr;

  pm_sample_pacer #(.AW(AW), .RATE_DIV(RATE_DIV), .PREFILL(PREFILL), .IDLE_VAL(8'h7F)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
`ifdef PACER_STATS_EN
    .clr_stats(clr_stats), .ovf_count(ovf_count), .udr_count(udr_count),
`endif
    .sample(sample), .sample_stb(sample_stb), .playing(playing), .level(level),
    .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [53:0] act_vec();
`ifdef PACER_STATS_EN
    return {ovf_count, udr_count, sample, sample_stb, playing, level, overflow, underrun};
`else
    return {32'h0, sample, sample_stb, playing, level, overflow, underrun};
`endif
  endfunction

  function automatic logic [53:0] exp_vec();
    logic [AW:0] lv = (AW+1)'(m_q.size());
`ifdef PACER_STATS_EN
    return {m_ovf_cnt, m_udr_cnt, m_sample, m_stb, m_play, lv, m_ovf, m_udr};
`else
    return {32'h0, m_sample, m_stb, m_play, lv, m_ovf, m_udr};
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_play = 1'b0; m_sample = 8'h7F;
    m_stb = 1'b0; m_ovf = 1'b0; m_udr = 1'b0;
`ifdef PACER_STATS_EN
    m_ovf_cnt = 16'h0; m_udr_cnt = 16'h0;
`endif
  endtask

  // One clock of the sample-pacing rules, evaluated on pre-edge model state.
  task automatic model_update(input bit v, input logic [7:0] d);
    bit tick = (m_cnt == RATE_DIV - 1);
    int pre  = m_q.size();
    bit play_pre = m_play;
`ifdef PACER_STATS_EN
    if (clr_stats) begin
      m_ovf_cnt = 16'h0; m_udr_cnt = 16'h0;
    end else begin
      if (m_ovf && m_ovf_cnt != 16'hFFFF) m_ovf_cnt = m_ovf_cnt + 16'd1;
      if (m_udr && m_udr_cnt != 16'hFFFF) m_udr_cnt = m_udr_cnt + 16'd1;
    end
`endif
    m_cnt = tick ? 0 : m_cnt + 1;
    m_stb = 1'b0; m_ovf = 1'b0; m_udr = 1'b0;
    if (play_pre && tick) begin
      if (pre > 0) begin
        m_sample = m_q.pop_front();
        m_stb = 1'b1;
      end else begin
        m_udr  = 1'b1;
        m_play = 1'b0;
      end
    end
    if (v) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else              m_q.push_back(d);
    end
    if (!play_pre && pre >= PREFILL) m_play = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
`ifdef PACER_STATS_EN
    clr_stats = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    in_valid = v; in_data = d;
    @(posedge clk);
    model_update(v, d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int stb_seen = 0;
    do_reset();
    n_cmp++;
    if ({sample, sample_stb, playing, level, overflow, underrun} !== {8'h7F, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values got=%h/%b/%b/%0d/%b/%b exp=7f/0/0/0/0/0", sample, sample_stb, playing, level, overflow, underrun);
    end
    for (int i = 0; i < 2000; i++) begin
      step(1'b0, 8'h00);
      if (sample_stb) stb_seen++;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL idle_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (stb_seen != 0 || sample !== 8'h7F || playing !== 1'b0 || level !== 10'd0) begin
      n_err++;
      $display("FAIL idle_hold got stbs=%0d sample=%h playing=%b level=%0d exp stbs=0 sample=7f playing=0 level=0", stb_seen, sample, playing, level);
    end
  endtask

  task automatic test_prefill_drain();
    int n_stb = 0, n_udr = 0, last = -1;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i));
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL prefill_write cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    step(1'b0, 8'h00);
    n_cmp++;
    if (playing !== 1'b1) begin
      n_err++;
      $display("FAIL prefill_play got=%b exp=1", playing);
    end
    for (int i = 0; i < 260 * RATE_DIV; i++) begin
      step(1'b0, 8'h00);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL drain_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (sample_stb) begin
        n_cmp++;
        if (sample !== 8'(n_stb) || (last >= 0 && cyc - last != RATE_DIV)) begin
          n_err++;
          $display("FAIL drain_stb got val=%h gap=%0d exp val=%h gap=%0d", sample, cyc - last, 8'(n_stb), RATE_DIV);
        end
        last = cyc; n_stb++;
      end
      if (underrun) n_udr++;
    end
    n_cmp++;
    if (n_stb != 256 || n_udr != 1 || sample !== 8'hFF || playing !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end got stbs=%0d udr=%0d sample=%h playing=%b exp 256/1/ff/0", n_stb, n_udr, sample, playing);
    end
  endtask

  task automatic test_sine_stream();
    logic [7:0] sine [64];
    logic [7:0] sent[$];
    int k = 0, bad_ev = 0;
    for (int i = 0; i < 64; i++)
      sine[i] = 8'($rtoi($sin(2.0 * 3.14159265358979 * i / 64.0) * 127.0 + 127.5));
    do_reset();
    for (int i = 0; i < PREFILL; i++) begin
      sent.push_back(sine[k % 64]);
      step(1'b1, sine[k % 64]); k++;
    end
    for (int w = 0; w < 300; w++) begin
      int off = $urandom_range(0, RATE_DIV - 1);
      for (int j = 0; j < RATE_DIV; j++) begin
        if (j == off) begin
          sent.push_back(sine[k % 64]);
          step(1'b1, sine[k % 64]); k++;
        end else begin
          step(1'b0, 8'h00);
        end
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL sine_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
        end
        if (overflow || underrun) bad_ev++;
        if (sample_stb) begin
          logic [7:0] want = sent.pop_front();
          n_cmp++;
          if (sample !== want) begin
            n_err++;
            $display("FAIL sine_order got=%h exp=%h", sample, want);
          end
        end
      end
    end
    n_cmp++;
    if (bad_ev != 0) begin
      n_err++;
      $display("FAIL sine_events got=%0d exp=0", bad_ev);
    end
  endtask

  task automatic test_overflow();
    int n_ovf = 0, m_ovfs = 0;
    bit saw_full = 1'b0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 8'($urandom));
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ovf_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (level === 10'd512) saw_full = 1'b1;
      if (overflow) n_ovf++;
      if (m_ovf) m_ovfs++;
    end
    n_cmp++;
    if (!saw_full || n_ovf != m_ovfs || n_ovf == 0) begin
      n_err++;
      $display("FAIL ovf_summary got full=%b ovf=%0d exp full=1 ovf=%0d", saw_full, n_ovf, m_ovfs);
    end
  endtask

  task automatic test_random();
    int dens = 5;
    do_reset();
    for (int i = 0; i < 8000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 4))
          0: dens = 2;
          1: dens = 5;
          2: dens = 8;
          3: dens = 30;
          default: dens = 100;
        endcase
      end
      if ($urandom_range(0, 1999) == 0) do_reset();
`ifdef PACER_STATS_EN
      clr_stats = ($urandom_range(0, 299) == 0);
`endif
      step($urandom_range(0, 99) < dens, 8'($urandom));
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
`ifdef PACER_STATS_EN
    clr_stats = 1'b0;
`endif
  endtask

`ifdef PACER_STATS_EN
  task automatic test_stats();
    int n_ovf = 0, guard = 0;
    bit udr_seen = 1'b0;
    do_reset();
    while (n_ovf < 3 && guard < 2000) begin
      step(1'b1, 8'($urandom)); guard++;
      if (m_ovf) n_ovf++;
    end
    for (int i = 0; i < (DEPTH + 4) * RATE_DIV && !udr_seen; i++) begin
      step(1'b0, 8'h00);
      if (m_udr) udr_seen = 1'b1;
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    n_cmp++;
    if (ovf_count !== 16'd3 || udr_count !== 16'd1) begin
      n_err++;
      $display("FAIL stats_count got ovf=%0d udr=%0d exp ovf=3 udr=1", ovf_count, udr_count);
    end
    clr_stats = 1'b1;
    step(1'b0, 8'h00);
    clr_stats = 1'b0;
    n_cmp++;
    if (ovf_count !== 16'd0 || udr_count !== 16'd0) begin
      n_err++;
      $display("FAIL stats_clear got ovf=%0d udr=%0d exp 0/0", ovf_count, udr_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
`ifdef PACER_STATS_EN
    clr_stats = 1'b0;
`endif
    model_reset();
    test_reset();
    test_prefill_drain();
    test_sine_stream();
    test_overflow();
    test_random();
`ifdef PACER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
